zion_riscv_add_sub_issue: RTL and testbench

- Decode/issue stage that drives the De side of the add/sub execution interface: op, s1, s2.
- Accepts a decoded-stage instruction word plus register-file operands over a valid/ready handshake.
- Classifies add/sub-class instructions (ADD/SUB/.W, SLT[I][U], branch compares, load/store address) and buffers results in a 2-entry skid buffer.
- The downstream adder/comparator sees a registered, stall-tolerant stream.

---
 rtl/zion_riscv_add_sub_issue.sv | 230 +++++++++++++++++++++++
 tb/tb_zion_riscv_add_sub_issue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/zion_riscv_add_sub_issue.sv
// Add/sub-class decode and issue stage feeding the adder/comparator through a 2-entry skid buffer.
// Define ZION_ADDSUB_ISSUE_ILLEGAL_EN to emit flagged (oIllegal) entries for unrecognized words.
module zion_riscv_add_sub_issue #(
  parameter int RV64 = 0,
  localparam int CPU_WIDTH = 32 * (RV64 + 1),
  localparam int OPW = RV64 + 2
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iFlush,
  input  logic                 iVld,
  output logic                 oRdy,
  input  logic [31:0]          iInstr,
  input  logic [CPU_WIDTH-1:0] iRs1Dat,
  input  logic [CPU_WIDTH-1:0] iRs2Dat,
  output logic                 oVld,
  input  logic                 iRdy,
  output logic [OPW-1:0]       oOp,
  output logic [CPU_WIDTH-1:0] oS1,
  output logic [CPU_WIDTH-1:0] oS2,
  output logic                 oCmp,
  output logic                 oUnsigned
`ifdef ZION_ADDSUB_ISSUE_ILLEGAL_EN
  ,
  output logic                 oIllegal
`endif
);

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] F7_ZERO     = 7'b0000000;
  localparam logic [6:0] F7_ALT      = 7'b0100000;

  localparam logic [OPW-1:0] OP_ADD = OPW'(3'b001);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3'b010);
  localparam logic [OPW-1:0] OP_W   = OPW'((RV64 != 0) ? 3'b100 : 3'b000);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPW-1:0]       op;
    logic [CPU_WIDTH-1:0] s1;
    logic [CPU_WIDTH-1:0] s2;
    logic                 cmp;
    logic                 uns;
`ifdef ZION_ADDSUB_ISSUE_ILLEGAL_EN
    logic                 ill;
`endif
  } entry_t;

  logic [6:0]           opc_s;
  logic [2:0]           f3_s;
  logic [6:0]           f7_s;
  logic [CPU_WIDTH-1:0] imm_i_s;
  logic [CPU_WIDTH-1:0] imm_s_s;
  logic                 rec_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 unused_s;
  entry_t               dec_s;
  entry_t               new_s;

  state_e state_q;
  entry_t head_q;
  entry_t skid_q;
  logic   vld_q;
  logic   rdy_q;

  assign opc_s    = iInstr[6:0];
  assign f3_s     = iInstr[14:12];
  assign f7_s     = iInstr[31:25];
  assign imm_i_s  = {{(CPU_WIDTH-12){iInstr[31]}}, iInstr[31:20]};
  assign imm_s_s  = {{(CPU_WIDTH-12){iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
  assign unused_s = ^iInstr[19:15];

  // Classify the incoming word and build its operand pair.
  always_comb begin
    dec_s    = '0;
    dec_s.s1 = iRs1Dat;
    dec_s.s2 = iRs2Dat;
    rec_s    = 1'b1;
    case (opc_s)
      OPC_OP, OPC_OPIMM: begin
        if (opc_s == OPC_OPIMM) begin
          dec_s.s2 = imm_i_s;
        end else begin
          dec_s.s2 = iRs2Dat;
        end
        if (opc_s == OPC_OP && f7_s == F7_ALT && f3_s == 3'b000) begin
          dec_s.op = OP_SUB;
        end else if (opc_s == OPC_OPIMM || f7_s == F7_ZERO) begin
          case (f3_s)
            3'b000:  dec_s.op = OP_ADD;
            3'b010:  {dec_s.op, dec_s.cmp} = {OP_SUB, 1'b1};
            3'b011:  {dec_s.op, dec_s.cmp, dec_s.uns} = {OP_SUB, 1'b1, 1'b1};
            default: rec_s = 1'b0;
          endcase
        end else begin
          rec_s = 1'b0;
        end
      end
      OPC_BRANCH: begin
        case (f3_s)
          3'b100, 3'b101: {dec_s.op, dec_s.cmp} = {OP_SUB, 1'b1};
          3'b110, 3'b111: {dec_s.op, dec_s.cmp, dec_s.uns} = {OP_SUB, 1'b1, 1'b1};
          default:        rec_s = 1'b0;
        endcase
      end
      OPC_LOAD:  {dec_s.op, dec_s.s2} = {OP_ADD, imm_i_s};
      OPC_STORE: {dec_s.op, dec_s.s2} = {OP_ADD, imm_s_s};
      OPC_OP32: begin
        if (RV64 != 0 && f3_s == 3'b000 && f7_s == F7_ZERO) begin
          dec_s.op = OP_ADD | OP_W;
        end else if (RV64 != 0 && f3_s == 3'b000 && f7_s == F7_ALT) begin
          dec_s.op = OP_SUB | OP_W;
        end else begin
          rec_s = 1'b0;
        end
      end
      OPC_OPIMM32: begin
        if (RV64 != 0 && f3_s == 3'b000) begin
          {dec_s.op, dec_s.s2} = {OP_ADD | OP_W, imm_i_s};
        end else begin
          rec_s = 1'b0;
        end
      end
      default: rec_s = 1'b0;
    endcase
  end

  // Select the entry to enqueue; unrecognized words become flagged entries or vanish.
  always_comb begin
    new_s = dec_s;
    pop_s = vld_q & iRdy;
`ifdef ZION_ADDSUB_ISSUE_ILLEGAL_EN
    push_s = iVld & rdy_q;
    if (!rec_s) begin
      new_s     = '0;
      new_s.ill = 1'b1;
    end else begin
      new_s = dec_s;
    end
`else
    push_s = iVld & rdy_q & rec_s;
`endif
  end

  // Skid buffer FSM: head_q drives the outputs, skid_q holds the second entry.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else if (iFlush) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          rdy_q <= 1'b1;
          if (push_s) begin
            head_q  <= new_s;
            vld_q   <= 1'b1;
            state_q <= ST_ONE;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          rdy_q <= ~(push_s & ~pop_s);
          if (push_s && !pop_s) begin
            skid_q  <= new_s;
            state_q <= ST_TWO;
          end else if (pop_s && !push_s) begin
            head_q  <= '0;
            vld_q   <= 1'b0;
            state_q <= ST_EMPTY;
          end else if (push_s && pop_s) begin
            head_q <= new_s;
          end else begin
            state_q <= ST_ONE;
          end
        end
        ST_TWO: begin
          rdy_q <= pop_s;
          if (pop_s) begin
            head_q  <= skid_q;
            skid_q  <= '0;
            state_q <= ST_ONE;
          end else begin
            state_q <= ST_TWO;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          head_q  <= '0;
          skid_q  <= '0;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign oRdy      = rdy_q;
  assign oVld      = vld_q;
  assign oOp       = head_q.op;
  assign oS1       = head_q.s1;
  assign oS2       = head_q.s2;
  assign oCmp      = head_q.cmp;
  assign oUnsigned = head_q.uns;
`ifdef ZION_ADDSUB_ISSUE_ILLEGAL_EN
  assign oIllegal  = head_q.ill;
`endif

endmodule

// File: tb/tb_zion_riscv_add_sub_issue.sv
// Directed plus random bench for zion_riscv_add_sub_issue (RV64=1) against a mnemonic-level FIFO model.
module tb_zion_riscv_add_sub_issue;

  logic        iClk = 1'b0;
  logic        iRst, iFlush, iVld, iRdy;
  logic        oRdy, oVld, oCmp, oUnsigned;
  logic [31:0] iInstr;
  logic [63:0] iRs1Dat, iRs2Dat, oS1, oS2;
  logic [2:0]  oOp;
`ifdef ZION_ADDSUB_ISSUE_ILLEGAL_EN
  logic        oIllegal;
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  always #5 iClk = ~iClk;

  zion_riscv_add_sub_issue #(.RV64(1)) dut (
    .iClk(iClk), .iRst(iRst), .iFlush(iFlush), .iVld(iVld), .oRdy(oRdy),
    .iInstr(iInstr), .iRs1Dat(iRs1Dat), .iRs2Dat(iRs2Dat), .oVld(oVld), .iRdy(iRdy),
    .oOp(oOp), .oS1(oS1), .oS2(oS2), .oCmp(oCmp), .oUnsigned(oUnsigned)
`ifdef ZION_ADDSUB_ISSUE_ILLEGAL_EN
    , .oIllegal(oIllegal)
`endif
  );

  typedef enum {M_NONE, M_ADD, M_SUB, M_SLT, M_SLTU, M_ADDI, M_SLTI, M_SLTIU, M_BLT, M_BGE,
                M_BLTU, M_BGEU, M_LOAD, M_STORE, M_ADDW, M_SUBW, M_ADDIW} mn_e;

  typedef struct packed {
    logic        ok;
    logic [2:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic        cmp;
    logic        uns;
    logic        ill;
  } ref_t;

  ref_t q[$];
  bit   mrdy;
  int   n_assert = 0;
  int   n_fail = 0;

  function automatic mn_e mnemonic(input logic [31:0] w);
    logic [6:0] f7 = w[31:25];
    logic [2:0] f3 = w[14:12];
    case (w[6:0])
      7'h33: begin
        if (f7 == 7'h00 && f3 == 3'd0) return M_ADD;
        if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
        if (f7 == 7'h00 && f3 == 3'd2) return M_SLT;
        if (f7 == 7'h00 && f3 == 3'd3) return M_SLTU;
        return M_NONE;
      end
      7'h13: return (f3 == 3'd0) ? M_ADDI : (f3 == 3'd2) ? M_SLTI : (f3 == 3'd3) ? M_SLTIU : M_NONE;
      7'h63: return (f3 == 3'd4) ? M_BLT : (f3 == 3'd5) ? M_BGE : (f3 == 3'd6) ? M_BLTU :
                    (f3 == 3'd7) ? M_BGEU : M_NONE;
      7'h03: return M_LOAD;
      7'h23: return M_STORE;
      7'h3B: return (f3 != 3'd0) ? M_NONE : (f7 == 7'h00) ? M_ADDW : (f7 == 7'h20) ? M_SUBW : M_NONE;
      7'h1B: return (f3 == 3'd0) ? M_ADDIW : M_NONE;
      default: return M_NONE;
    endcase
  endfunction

  function automatic ref_t ref_decode(input logic [31:0] w, input logic [63:0] a, input logic [63:0] b);
    ref_t e;
    mn_e  m = mnemonic(w);
    logic [63:0] imm_i = {{52{w[31]}}, w[31:20]};
    logic [63:0] imm_s = {{52{w[31]}}, w[31:25], w[11:7]};
    e = '0;
    if (m == M_NONE) begin
      e.ok  = ILL_EN;
      e.ill = 1'b1;
      return e;
    end
    e.ok = 1'b1;
    e.s1 = a;
    e.s2 = (m inside {M_ADDI, M_SLTI, M_SLTIU, M_LOAD, M_ADDIW}) ? imm_i : (m == M_STORE) ? imm_s : b;
    e.cmp = m inside {M_SLT, M_SLTU, M_SLTI, M_SLTIU, M_BLT, M_BGE, M_BLTU, M_BGEU};
    e.uns = m inside {M_SLTU, M_SLTIU, M_BLTU, M_BGEU};
    e.op[0] = m inside {M_ADD, M_ADDI, M_LOAD, M_STORE, M_ADDW, M_ADDIW};
    e.op[1] = !e.op[0];
    e.op[2] = m inside {M_ADDW, M_SUBW, M_ADDIW};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ref_t e = (q.size() > 0) ? q[0] : '0;
    chk("oVld", 64'(oVld), 64'(q.size() > 0));
    chk("oRdy", 64'(oRdy), 64'(mrdy));
    chk("oOp", 64'(oOp), 64'(e.op));
    chk("oS1", oS1, e.s1);
    chk("oS2", oS2, e.s2);
    chk("oCmp", 64'(oCmp), 64'(e.cmp));
    chk("oUnsigned", 64'(oUnsigned), 64'(e.uns));
`ifdef ZION_ADDSUB_ISSUE_ILLEGAL_EN
    chk("oIllegal", 64'(oIllegal), 64'(e.ill));
`endif
  endtask

  // Drive one cycle after the falling edge, step the model at the rising edge, check at the next fall.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                     input logic r, input logic f);
    bit acc;
    iVld = v; iInstr = ins; iRs1Dat = a; iRs2Dat = b; iRdy = r; iFlush = f;
    @(posedge iClk);
    if (f) begin
      q.delete();
      mrdy = 1'b1;
    end else begin
      acc = v && mrdy;
      if (q.size() > 0 && r) void'(q.pop_front());
      if (acc) begin
        ref_t e = ref_decode(ins, a, b);
        if (e.ok) q.push_back(e);
      end
      mrdy = (q.size() < 2);
    end
    @(negedge iClk);
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [8] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h3B, 7'h1B, 7'h00};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 8);
    if (k < 8) begin
      w[6:0] = opcs[k];
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 2) == 0) w[14:12] = 3'd0;
    end
    return w;
  endfunction

  initial begin
    iRst = 1'b1; iFlush = 1'b0; iVld = 1'b0; iRdy = 1'b0;
    iInstr = 32'd0; iRs1Dat = 64'd0; iRs2Dat = 64'd0;
    mrdy = 1'b0;
    #12;
    check_all();
    @(negedge iClk);
    iRst = 1'b0;
    cyc(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("rdy_after_reset", 64'(oRdy), 64'd1);

    cyc(1'b1, 32'h002081B3, 64'd5, 64'd7, 1'b1, 1'b0);
    chk("tp_add_vld", 64'(oVld), 64'd1);
    chk("tp_add_op", 64'(oOp), 64'(3'b001));
    chk("tp_add_s1", oS1, 64'd5);
    chk("tp_add_s2", oS2, 64'd7);
    chk("tp_add_cmp", 64'(oCmp), 64'd0);

    cyc(1'b1, 32'hFFF0819B, 64'h7FFF_FFFF, 64'h1234, 1'b1, 1'b0);
    chk("tp_addiw_op", 64'(oOp), 64'(3'b101));
    chk("tp_addiw_s2", oS2, 64'hFFFF_FFFF_FFFF_FFFF);

    cyc(1'b1, 32'h0020E063, 64'd1, 64'h8000_0000, 1'b1, 1'b0);
    chk("tp_bltu_sub", 64'(oOp[1]), 64'd1);
    chk("tp_bltu_cmp", 64'(oCmp), 64'd1);
    chk("tp_bltu_uns", 64'(oUnsigned), 64'd1);
    chk("tp_bltu_s2", oS2, 64'h8000_0000);
    cyc(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);

    for (int i = 1; i <= 3; i++) cyc(1'b1, 32'h002081B3, 64'(i), 64'd0, 1'b0, 1'b0);
    chk("bp_rdy_low", 64'(oRdy), 64'd0);
    chk("bp_head_held", oS1, 64'd1);
    cyc(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("bp_second", oS1, 64'd2);
    chk("bp_rdy_back", 64'(oRdy), 64'd1);
    cyc(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("bp_drained", 64'(oVld), 64'd0);

    cyc(1'b1, 32'h002081B3, 64'd10, 64'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h002081B3, 64'd11, 64'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h002081B3, 64'd99, 64'd0, 1'b0, 1'b1);
    chk("flush_vld", 64'(oVld), 64'd0);
    chk("flush_rdy", 64'(oRdy), 64'd1);
    cyc(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("flush_dropped", 64'(oVld), 64'd0);

    cyc(1'b1, 32'h0000_0000, 64'd3, 64'd4, 1'b1, 1'b0);
    chk("illegal_vld", 64'(oVld), 64'(ILL_EN));
    chk("illegal_op", 64'(oOp), 64'd0);
    cyc(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);

    cyc(1'b1, 32'h002081B3, 64'd42, 64'd1, 1'b0, 1'b0);
    #2;
    iRst = 1'b1;
    #1;
    q.delete();
    mrdy = 1'b0;
    check_all();
    @(negedge iClk);
    iRst = 1'b0;
    cyc(1'b0, 32'd0, 64'd0, 64'd0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
